// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: downstream control, instruction-memory port and the
// instruction handed downstream.
interface inst_fetch_if;
    logic        stall;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] fetch_count;

    // master: the fetch unit; slave: pipeline plus instruction memory
    modport master (
        input  stall, redirect, redirect_pc, imem_inst,
        output imem_addr, if_inst, if_pc, if_valid, fetch_count
    );
    modport slave (
        output stall, redirect, redirect_pc, imem_inst,
        input  imem_addr, if_inst, if_pc, if_valid, fetch_count
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage driving a synchronous-read instruction memory.
// pc_r tracks the memory's address register so if_pc always matches imem_inst.
module inst_fetch (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    localparam logic [1:0] StBoot      = 2'd0;
    localparam logic [1:0] StRun       = 2'd1;
    localparam logic [1:0] StHoldRedir = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [29:0] pc_r;
    logic [29:0] pend_pc, pend_pc_d;
    logic [29:0] next_addr;
    logic [31:0] fetch_count_q;
    logic        valid;

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc;
        next_addr = pc_r;
        unique case (state_q)
            StBoot: begin
                next_addr = 30'd0;
                state_d   = StRun;
            end
            StRun: begin
                if (!bus.stall) begin
                    next_addr = bus.redirect ? bus.redirect_pc : pc_r + 30'd1;
                end else if (bus.redirect) begin
                    // Memory must keep re-reading the held instruction; park the target.
                    pend_pc_d = bus.redirect_pc;
                    state_d   = StHoldRedir;
                end
            end
            StHoldRedir: begin
                if (bus.stall) begin
                    if (bus.redirect) pend_pc_d = bus.redirect_pc;
                end else begin
                    next_addr = bus.redirect ? bus.redirect_pc : pend_pc;
                    state_d   = StRun;
                end
            end
            default: begin
                next_addr = 30'd0;
                state_d   = StBoot;
            end
        endcase
    end

    assign valid = (state_q == StRun) || (state_q == StHoldRedir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_r          <= 30'd0;
            pend_pc       <= 30'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_r    <= next_addr;
            pend_pc <= pend_pc_d;
            if (valid && !bus.stall) fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.imem_addr   = next_addr;
    assign bus.if_valid    = valid;
    assign bus.if_inst     = valid ? bus.imem_inst : 32'h0000_0000;
    assign bus.if_pc       = {pc_r, 2'b00};
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-high; held for at least one rising clk edge so the instruction memory's synchronous address register also clears.
REQ-003 SHALL: stall  input  1  downstream cannot accept the current instruction; hold it.
REQ-004 SHALL: redirect  input  1  branch/jump resolved downstream; next fetch goes to redirect_pc.
REQ-005 SHALL: redirect_pc  input  30  word address of the redirect target.
REQ-006 SHALL: imem_addr  output  30  word address driven to instruction memory; memory registers it on the same edge and returns data the following cycle.
REQ-007 SHALL: imem_inst  input  32  instruction word for the address captured at the previous edge.
REQ-008 SHALL: if_inst  output  32  instruction handed downstream.
REQ-009 SHALL: if_pc  output  32  byte address of if_inst, {pc_r, 2'b00}.
REQ-010 SHALL: if_valid  output  1  if_inst is a real fetched instruction.
REQ-011 SHALL: fetch_count  output  32  number of instructions accepted downstream.

Function
REQ-012 SHALL: pc_r (30 b) mirrors the memory's address register: pc_r <= imem_addr on every edge.
REQ-013 SHALL: implement states BOOT, RUN, HOLD_REDIR; pending-target register pend_pc (30 b).
REQ-014 SHALL: BOOT: imem_addr = 0, if_valid = 0; unconditionally -> RUN at next edge.
REQ-015 SHALL: RUN, stall=0, redirect=0: imem_addr = pc_r + 1, wrapping 30'h3FFFFFFF -> 0.
REQ-016 SHALL: RUN, stall=0, redirect=1: imem_addr = redirect_pc; stay RUN.
REQ-017 SHALL: RUN, stall=1, redirect=0: imem_addr = pc_r; stay RUN.
REQ-018 SHALL: RUN, stall=1, redirect=1: imem_addr = pc_r; pend_pc <= redirect_pc; -> HOLD_REDIR.
REQ-019 SHALL: HOLD_REDIR, stall=1: imem_addr = pc_r; if redirect=1, pend_pc <= redirect_pc (latest wins); stay HOLD_REDIR.
REQ-020 SHALL: HOLD_REDIR, stall=0: imem_addr = redirect ? redirect_pc : pend_pc; -> RUN.
REQ-021 SHALL: imem_addr is combinational from state, pc_r, pend_pc, stall, redirect, redirect_pc; no added latency beyond the memory's one cycle.
REQ-022 SHALL: if_valid = 1 in RUN and HOLD_REDIR; if_inst = if_valid ? imem_inst : 32'h00000000 (NOP bubble).
REQ-023 SHALL: fetch_count increments by 1 on each edge with if_valid=1 and stall=0; wraps 32'hFFFFFFFF -> 0.
REQ-024 SHALL: while stall=1, if_inst and if_pc remain unchanged cycle to cycle.
REQ-025 SHALL: no instruction is dropped or duplicated toward downstream: each accepted (if_valid & !stall) cycle presents a distinct fetch.
REQ-026 SHALL: redirect with stall=0 does not squash the currently presented instruction (delay slot is executed).

Reset
REQ-027 SHALL: on rst=1, immediately (asynchronously): state=BOOT, pc_r=0, pend_pc=0, fetch_count=0; hence imem_addr=0, if_valid=0, if_inst=0, if_pc=0.
REQ-028 SHALL: rst asserted mid-stall or in HOLD_REDIR discards the pending redirect; fetch restarts at address 0.
REQ-029 SHALL: first cycle after rst release is BOOT; first valid instruction (address 0) appears one cycle later.

Verification
REQ-030 SHALL: reset release, stall=0, no redirect, 4 cycles -> cycle0 if_valid=0; then if_pc = 0x0, 0x4, 0x8 with if_inst = mem[0], mem[1], mem[2]; fetch_count=3.
REQ-031 SHALL: at if_pc=0x8, stall=1 for 3 cycles -> if_pc holds 0x8, imem_addr=2, fetch_count frozen; after release if_pc=0xC.
REQ-032 SHALL: at if_pc=0x4, redirect=1, redirect_pc=0x21 -> next if_pc=0x84 with if_inst=mem[0x21]; then 0x88.
REQ-033 SHALL: at if_pc=0x10, stall=1 and redirect=1 (0x21), then redirect=0, stall=1 two more cycles, then stall=0 -> if_pc held 0x10, then 0x84.
REQ-034 SHALL: in HOLD_REDIR, second redirect to 0x30 while stalled -> after release if_pc=0xC0 (latest wins).
REQ-035 SHALL: pc_r=30'h3FFFFFFF, stall=0 -> imem_addr=0; async rst pulse mid-cycle in HOLD_REDIR -> outputs zero immediately, pending target lost.
